alarm_control: RTL

- Alarm sequencer for the clock datapath.
- Holds the alarm hour/minute registers, which are edited with the shared set/up/down/left/right buttons.
- Compares the alarm against the running time from the clock counters and drives the ring output, with auto-stop and snooze.
- Sits beside the timer controller and consumes the same button pulses and seconds tick.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_control_if.sv | 28 ++
 rtl/alarm_sec_countdown.sv | 24 ++
 rtl/alarm_control.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared widths, state encodings and field-wrap helper for the alarm sequencer
package alarm_pkg;
    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int CNT_W = 10;
    localparam logic [5:0] HR_MAX  = 6'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_ARMED   = 3'b001;
    localparam logic [2:0] ST_SET_MIN = 3'b010;
    localparam logic [2:0] ST_SET_HR  = 3'b011;
    localparam logic [2:0] ST_RING    = 3'b100;
    localparam logic [2:0] ST_SNOOZE  = 3'b101;
    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ARMED   = ST_ARMED,
        SET_MIN = ST_SET_MIN,
        SET_HR  = ST_SET_HR,
        RING    = ST_RING,
        SNOOZE  = ST_SNOOZE
    } state_t;
    // one up/down step of a time field, wrapping between 0 and lim; up+down together cancel
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] lim, input logic up, input logic dn);
        return (up & ~dn) ? ((v == lim) ? 6'd0 : v + 6'd1) :
               (dn & ~up) ? ((v == 6'd0) ? lim : v - 6'd1) : v;
    endfunction
endpackage

// File: rtl/alarm_control_if.sv
// alarm_control_if: button pulses, running time and alarm status outputs of the alarm sequencer
interface alarm_control_if;
    import alarm_pkg::*;
    logic             i_set;
    logic             i_up;
    logic             i_down;
    logic             i_left;
    logic             i_right;
    logic             i_sec_pulse;
    logic [HR_W-1:0]  i_hr;
    logic [MIN_W-1:0] i_min;
    logic [SEC_W-1:0] i_sec;
    logic [HR_W-1:0]  o_alarm_hr;
    logic [MIN_W-1:0] o_alarm_min;
    logic             o_armed;
    logic             o_ring;
    logic             o_set_min;
    logic             o_set_hr;
    logic             o_snoozing;
    modport master (
        output i_set, i_up, i_down, i_left, i_right, i_sec_pulse, i_hr, i_min, i_sec,
        input  o_alarm_hr, o_alarm_min, o_armed, o_ring, o_set_min, o_set_hr, o_snoozing
    );
    modport slave (
        input  i_set, i_up, i_down, i_left, i_right, i_sec_pulse, i_hr, i_min, i_sec,
        output o_alarm_hr, o_alarm_min, o_armed, o_ring, o_set_min, o_set_hr, o_snoozing
    );
endinterface

// File: rtl/alarm_sec_countdown.sv
// alarm_sec_countdown: loadable seconds down-counter; o_done flags the tick that takes it from 1 to 0
module alarm_sec_countdown
    import alarm_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_run,
    input  logic             i_tick,
    output logic             o_done
);
    logic [CNT_W-1:0] r_cnt;
    assign o_done = i_run & i_tick & (r_cnt == CNT_W'(1));
    // load wins over counting; the counter holds at zero
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_run & i_tick & (r_cnt != '0))
            r_cnt <= r_cnt - CNT_W'(1);
    end
endmodule

// File: rtl/alarm_control.sv
// alarm_control: alarm time editor, match trigger, ring auto-stop and snooze (snooze built only with ALARM_SNOOZE_EN)
module alarm_control
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    alarm_control_if.slave  bus
);
    if (RING_SECS < 1 || RING_SECS > 255 || SNOOZE_SECS < 1 || SNOOZE_SECS > 1023 ||
        MAX_SNOOZE < 0 || MAX_SNOOZE > 7) begin : g_bad_cfg
        $error("alarm_control: parameter out of range");
    end
    state_t           r_state, w_state_n;
    logic [HR_W-1:0]  r_hr, w_hr_n;
    logic [MIN_W-1:0] r_min, w_min_n;
    logic [2:0]       r_snz, w_snz_n;
    logic             r_armed, r_ring, r_set_min, r_set_hr, r_snoozing;
    logic             w_load, w_done, w_trig, w_rlud, w_swap;
    logic [CNT_W-1:0] w_load_val;
    logic [5:0]       w_min_step, w_hr_step;
    assign w_trig     = bus.i_sec_pulse & (bus.i_hr == r_hr) & (bus.i_min == r_min) & (bus.i_sec == '0);
    assign w_rlud     = bus.i_up | bus.i_down | bus.i_left | bus.i_right;
    assign w_swap     = bus.i_left ^ bus.i_right;
    assign w_min_step = wrap_step(r_min, MIN_MAX, bus.i_up, bus.i_down);
    assign w_hr_step  = wrap_step({1'b0, r_hr}, HR_MAX, bus.i_up, bus.i_down);
    alarm_sec_countdown u_cnt (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_run      ((r_state == RING) | (r_state == SNOOZE)),
        .i_tick     (bus.i_sec_pulse),
        .o_done     (w_done)
    );
    // next state and alarm registers; i_set beats trigger/timeout, which beat the rlud buttons
    always_comb begin
        w_state_n  = r_state;
        w_hr_n     = r_hr;
        w_min_n    = r_min;
        w_snz_n    = r_snz;
        w_load     = 1'b0;
        w_load_val = CNT_W'(RING_SECS);
        case (r_state)
            IDLE:  w_state_n = bus.i_set ? SET_MIN : bus.i_up ? ARMED : IDLE;
            ARMED: begin
                w_state_n = bus.i_set ? SET_MIN : w_trig ? RING : bus.i_down ? IDLE : ARMED;
                w_load    = ~bus.i_set & w_trig;
            end
            SET_MIN: begin
                w_min_n   = bus.i_set ? r_min : w_min_step;
                w_state_n = bus.i_set ? ARMED : w_swap ? SET_HR : SET_MIN;
            end
            SET_HR: begin
                w_hr_n    = bus.i_set ? r_hr : w_hr_step[HR_W-1:0];
                w_state_n = bus.i_set ? ARMED : w_swap ? SET_MIN : SET_HR;
            end
            RING: begin
                if (bus.i_set || w_done) begin
                    w_state_n = ARMED;
                    w_snz_n   = '0;
                end else if (w_rlud) begin
`ifdef ALARM_SNOOZE_EN
                    if (r_snz < 3'(MAX_SNOOZE)) begin
                        w_state_n  = SNOOZE;
                        w_load     = 1'b1;
                        w_load_val = CNT_W'(SNOOZE_SECS);
                        w_snz_n    = r_snz + 3'd1;
                    end else begin
                        w_state_n = ARMED;
                        w_snz_n   = '0;
                    end
`else
                    w_state_n = ARMED;
                    w_snz_n   = '0;
`endif
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (bus.i_set) begin
                    w_state_n = ARMED;
                    w_snz_n   = '0;
                end else if (w_done) begin
                    w_state_n = RING;
                    w_load    = 1'b1;
                end
            end
`endif
            default: w_state_n = IDLE;
        endcase
    end
    // state, alarm time and outputs all registered from the next-state decode
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= IDLE;
            r_hr       <= '0;
            r_min      <= '0;
            r_snz      <= '0;
            r_armed    <= 1'b0;
            r_ring     <= 1'b0;
            r_set_min  <= 1'b0;
            r_set_hr   <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_hr       <= w_hr_n;
            r_min      <= w_min_n;
            r_snz      <= w_snz_n;
            r_armed    <= w_state_n inside {ARMED, RING, SNOOZE};
            r_ring     <= w_state_n == RING;
            r_set_min  <= w_state_n == SET_MIN;
            r_set_hr   <= w_state_n == SET_HR;
            r_snoozing <= w_state_n == SNOOZE;
        end
    end
    assign bus.o_alarm_hr  = r_hr;
    assign bus.o_alarm_min = r_min;
    assign bus.o_armed     = r_armed;
    assign bus.o_ring      = r_ring;
    assign bus.o_set_min   = r_set_min;
    assign bus.o_set_hr    = r_set_hr;
`ifdef ALARM_SNOOZE_EN
    assign bus.o_snoozing  = r_snoozing;
`else
    assign bus.o_snoozing  = 1'b0;
`endif
endmodule
